// File: rtl/xnor_operand_serializer_pkg.sv
// Shared definitions for the bit-serial operand link feeding the wide XNOR stage.
// Holds the default operand width, FSM state encodings and the counter-width helper.
package xnor_operand_serializer_pkg;

    localparam int unsigned DefaultWide = 3 * 3 * 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/xnor_operand_serializer.sv
// Serialises one activation/weight operand pair MSB first onto a/w, one bit per
// enabled cycle, then pulses frame_done once the consumer holds the full pair.
module xnor_operand_serializer
    import xnor_operand_serializer_pkg::*;
#(
    parameter int unsigned wide = DefaultWide
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [wide-1:0] a_vec,
    input  logic [wide-1:0] w_vec,
    input  logic            shift_en,
    output logic            a,
    output logic            w,
    output logic            bit_valid,
    output logic            last,
    output logic            frame_done
);

    localparam int unsigned CNT_W = cnt_width(wide);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(wide - 1);

    state_e            state_q, state_d;
    logic [wide-1:0]   a_sh_q, a_sh_d;
    logic [wide-1:0]   w_sh_q, w_sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              at_last;

    assign at_last = (cnt_q == LastCnt);

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        w_sh_d     = w_sh_q;
        cnt_d      = cnt_q;
        in_ready   = 1'b0;
        a          = 1'b0;
        w          = 1'b0;
        bit_valid  = 1'b0;
        last       = 1'b0;
        frame_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d  = a_vec;
                    w_sh_d  = w_vec;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a         = a_sh_q[wide-1];
                w         = w_sh_q[wide-1];
                bit_valid = shift_en;
                last      = shift_en && at_last;
                if (shift_en) begin
                    a_sh_d = a_sh_q << 1;
                    w_sh_d = w_sh_q << 1;
                    // Counter is parked at zero on the final transfer so it never exceeds wide-1.
                    if (at_last) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDone: begin
                frame_done = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            w_sh_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            w_sh_q  <= w_sh_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_xnor_operand_serializer.sv
// Scoreboard bench: frames are queued as expected bit streams at handshake and a
// negedge monitor checks every serial output, frame_done and a modelled consumer register.
module tb_xnor_operand_serializer;

    localparam int unsigned Wide  = 8;
    localparam int          Limit = 200;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [Wide-1:0] a_vec = '0;
    logic [Wide-1:0] w_vec = '0;
    logic            shift_en = 1'b1;
    logic            a, w, bit_valid, last, frame_done;

    logic            in1_valid = 1'b0;
    logic            in1_ready;
    logic [0:0]      a1_vec = 1'b0;
    logic [0:0]      w1_vec = 1'b0;
    logic            a1, w1, bit_valid1, last1, frame_done1;

    int checks = 0;
    int failures = 0;

    logic [2:0]      bq[$];
    logic [Wide-1:0] xq[$];
    logic [Wide-1:0] x_reg = '0;
    logic            done_due = 1'b0;
    logic            idle_due = 1'b0;
    logic            rand_stall = 1'b0;
    int              bits_seen = 0;

    xnor_operand_serializer #(.wide(Wide)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_vec(a_vec), .w_vec(w_vec), .shift_en(shift_en), .a(a), .w(w),
        .bit_valid(bit_valid), .last(last), .frame_done(frame_done)
    );

    xnor_operand_serializer #(.wide(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in1_valid), .in_ready(in1_ready),
        .a_vec(a1_vec), .w_vec(w1_vec), .shift_en(shift_en), .a(a1), .w(w1),
        .bit_valid(bit_valid1), .last(last1), .frame_done(frame_done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream: MSB first, last flagged on bit 0; consumer ends up with the XNOR.
    task automatic push_frame(input logic [Wide-1:0] av, input logic [Wide-1:0] wv);
        for (int i = Wide - 1; i >= 0; i--) begin
            bq.push_back({av[i], wv[i], (i == 0)});
        end
        xq.push_back(~(av ^ wv));
    endtask

    task automatic accept(input logic [Wide-1:0] av, input logic [Wide-1:0] wv,
                          output int waited);
        bit ok;
        in_valid = 1'b1;
        a_vec    = av;
        w_vec    = wv;
        waited   = 0;
        ok       = 1'b0;
        for (int n = 0; n < Limit; n++) begin
            @(negedge clk);
            waited++;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            push_frame(av, wv);
            #1;
            in_valid = 1'b0;
            a_vec    = Wide'($urandom);
            w_vec    = Wide'($urandom);
        end
    endtask

    // Called at posedge+1 after a handshake; returns the cycle index of frame_done.
    task automatic wait_done(input bit stall, output int n_done);
        n_done = -1;
        for (int n = 1; n < Limit; n++) begin
            shift_en = !(stall && n >= 3 && n <= 5);
            @(negedge clk);
            if (frame_done) begin
                n_done = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        shift_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (done_due) begin
                chk("frame_done_pulse", frame_done, 1'b1);
                if (xq.size() != 0) chk("consumer_xnor", x_reg, xq.pop_front());
                else chk("consumer_queue_empty", 64'd0, 64'd1);
            end else begin
                chk("frame_done_idle", frame_done, 1'b0);
            end
            if (idle_due) chk("ready_after_done", in_ready, 1'b1);
            idle_due = done_due;
            done_due = 1'b0;

            if (bq.size() == 0) begin
                chk("idle_outputs", {a, w, bit_valid, last}, 4'b0000);
            end else begin
                chk("busy_not_ready", in_ready, 1'b0);
                chk("bit_valid_follows_en", bit_valid, shift_en);
                if (bit_valid) begin
                    logic [2:0] e;
                    e = bq.pop_front();
                    chk("serial_aw_last", {a, w, last}, e);
                    x_reg = {x_reg[Wide-2:0], ~(a ^ w)};
                    bits_seen++;
                    if (e[0]) done_due = 1'b1;
                end else begin
                    chk("last_while_stalled", last, 1'b0);
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_stall) shift_en = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        int n_done;
        int base;
        logic [Wide-1:0] ra, rw;

        #12;
        reset = 1'b0;

        // Idle after reset: ready, all serial outputs quiet.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_ready", in_ready, 1'b1);
            chk("reset_ready_w1", in1_ready, 1'b1);
        end

        // Single-bit operand: first bit is also the last.
        @(posedge clk);
        #1;
        in1_valid = 1'b1;
        a1_vec    = 1'b1;
        w1_vec    = 1'b0;
        @(posedge clk);
        #1;
        in1_valid = 1'b0;
        @(negedge clk);
        chk("w1_bit", {a1, w1, bit_valid1, last1, frame_done1}, 5'b10110);
        @(negedge clk);
        chk("w1_done", {bit_valid1, last1, frame_done1, in1_ready}, 4'b0010);
        @(negedge clk);
        chk("w1_idle", {frame_done1, in1_ready}, 2'b01);

        // Reference pattern, no stalls.
        @(posedge clk);
        #1;
        accept(8'hA5, 8'h3C, waited);
        wait_done(1'b0, n_done);
        chk("latency_no_stall", n_done, Wide + 1);

        // Same pattern with a 3-cycle stall after bit 2.
        @(posedge clk);
        #1;
        accept(8'hA5, 8'h3C, waited);
        wait_done(1'b1, n_done);
        chk("latency_stall3", n_done, Wide + 1 + 3);

        // Second pair held during SHIFT is taken right after frame_done.
        @(posedge clk);
        #1;
        accept(8'h5A, 8'hF0, waited);
        accept(8'h0F, 8'h99, waited);
        chk("accept_spacing", waited, Wide + 2);
        wait_done(1'b0, n_done);
        chk("latency_second", n_done, Wide + 1);

        // Async reset mid-frame aborts it without frame_done.
        @(posedge clk);
        #1;
        base = bits_seen;
        accept(8'hC3, 8'h7E, waited);
        for (int n = 0; n < Limit && bits_seen < base + 4; n++) begin
            @(negedge clk);
            #1;
        end
        chk("bits_before_reset", bits_seen - base, 4);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_async_outputs", {a, w, bit_valid, last, frame_done}, 5'b00000);
        chk("reset_async_ready", in_ready, 1'b1);
        bq.delete();
        xq.delete();
        x_reg    = '0;
        done_due = 1'b0;
        idle_due = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        accept(8'h81, 8'h42, waited);
        wait_done(1'b0, n_done);
        chk("latency_after_reset", n_done, Wide + 1);

        // Randomised frames with random stalls and gaps.
        rand_stall = 1'b1;
        for (int f = 0; f < 30; f++) begin
            ra = Wide'($urandom);
            rw = Wide'($urandom);
            accept(ra, rw, waited);
            for (int g = $urandom_range(0, 2); g > 0; g--) @(posedge clk);
            #1;
        end
        for (int n = 0; n < Limit && (bq.size() != 0 || xq.size() != 0); n++) @(negedge clk);
        rand_stall = 1'b0;
        shift_en   = 1'b1;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", bq.size() + xq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
